// File: rtl/ssp_sample_framer.sv
// ---------------------------------------------------------------------------
// ssp_sample_framer
//
// Buffers 8-bit samples from the active mode module in a small FIFO and
// serialises them MSB-first onto the SSP pins toward the ARM. All timing is
// derived from the single fabric clock ck_1356meg.
//
// Ports
//   ck_1356meg    in   fabric clock, rising edge
//   reset         in   asynchronous, active-high reset
//   enable        in   1 = may start new bytes; 0 = finish byte, then idle
//   flush         in   synchronous FIFO clear (byte in flight completes)
//   sample_data   in   [7:0] sample to queue
//   sample_valid  in   sample_data valid this cycle
//   sample_ready  out  FIFO not full
//   overflow_clr  in   clears the sticky overflow flag
//   overflow      out  sticky: a sample was offered while not ready
//   fifo_level    out  [$clog2(DEPTH):0] current FIFO occupancy
//   busy          out  a byte is being shifted out
//   ssp_clk       out  serial clock, high for the first half of each bit
//   ssp_frame     out  high during the bit-7 period of each byte
//   ssp_din       out  serial data, MSB first
// ---------------------------------------------------------------------------
module ssp_sample_framer #(
   parameter int DEPTH   = 16,  // power of two, >= 2
   parameter int CLK_DIV = 8    // even, >= 2
) (
   input  logic                     ck_1356meg,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     flush,
   input  logic [7:0]               sample_data,
   input  logic                     sample_valid,
   output logic                     sample_ready,
   input  logic                     overflow_clr,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy,
   output logic                     ssp_clk,
   output logic                     ssp_frame,
   output logic                     ssp_din
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = $clog2(CLK_DIV);

   localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
   localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);      // edge that begins the next bit
   localparam logic [DW-1:0] DIV_HALF   = DW'(CLK_DIV / 2 - 1);  // edge that drops ssp_clk

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // ------------------------------------------------------------------------
   // FIFO storage and bookkeeping
   // ------------------------------------------------------------------------
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q,  level_d;
   logic          overflow_q, overflow_d;

   logic          push;
   logic          drop;
   logic          pop;
   logic [7:0]    rd_data;

   // ------------------------------------------------------------------------
   // Serialiser state
   // ------------------------------------------------------------------------
   state_e        state_q;
   logic [DW-1:0] div_cnt_q;
   logic [3:0]    bit_cnt_q;   // next bit to present; bit 3 set = all 8 bits presented
   logic [7:0]    shift_q;
   logic          ssp_clk_q;
   logic          ssp_frame_q;
   logic          ssp_din_q;
   logic          busy_q;

   assign sample_ready = (level_q != LEVEL_FULL);
   assign push         = sample_valid &&  sample_ready;
   assign drop         = sample_valid && !sample_ready;
   assign rd_data      = mem[rd_ptr_q];

   // A new byte is taken either from idle or exactly at the boundary that
   // ends bit 0 of the current byte, so consecutive bytes run without a gap.
   assign pop = enable && (level_q != '0) &&
                ((state_q == ST_IDLE) ||
                 (div_cnt_q == DIV_LAST && bit_cnt_q[3]));

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;

      if (flush) begin
         // Flush discards everything queued, including a same-cycle push.
         rd_ptr_d = wr_ptr_q;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end

      // Set has priority over clear.
      if (drop)              overflow_d = 1'b1;
      else if (overflow_clr) overflow_d = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge ck_1356meg or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: the sample memory is deliberately not reset; a location is only
   // read after it has been written, and leaving it out of reset lets it map
   // onto plain RAM.
   always_ff @(posedge ck_1356meg) begin
      if (push && !flush) mem[wr_ptr_q] <= sample_data;
   end

   // ------------------------------------------------------------------------
   // Serialiser FSM. Outputs are registered and only change on the edge that
   // raises ssp_clk, except ssp_clk itself which drops mid-period.
   // ------------------------------------------------------------------------
   always_ff @(posedge ck_1356meg or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         div_cnt_q   <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         ssp_clk_q   <= 1'b0;
         ssp_frame_q <= 1'b0;
         ssp_din_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  // Load now; preset the divider so the very next edge is a
                  // bit boundary that presents bit 7.
                  state_q   <= ST_SHIFT;
                  shift_q   <= rd_data;
                  bit_cnt_q <= 4'd7;
                  div_cnt_q <= DIV_LAST;
               end
            end

            ST_SHIFT: begin
               if (div_cnt_q == DIV_LAST) begin
                  div_cnt_q <= '0;
                  if (!bit_cnt_q[3]) begin
                     ssp_clk_q   <= 1'b1;
                     ssp_frame_q <= (bit_cnt_q == 4'd7);
                     ssp_din_q   <= shift_q[bit_cnt_q[2:0]];
                     busy_q      <= 1'b1;
                     bit_cnt_q   <= bit_cnt_q - 4'd1;   // 0 wraps to the done marker
                  end else if (pop) begin
                     // Back-to-back: next byte's bit 7 starts on this edge.
                     shift_q     <= rd_data;
                     ssp_clk_q   <= 1'b1;
                     ssp_frame_q <= 1'b1;
                     ssp_din_q   <= rd_data[7];
                     busy_q      <= 1'b1;
                     bit_cnt_q   <= 4'd6;
                  end else begin
                     state_q     <= ST_IDLE;
                     ssp_clk_q   <= 1'b0;
                     ssp_frame_q <= 1'b0;
                     ssp_din_q   <= 1'b0;
                     busy_q      <= 1'b0;
                  end
               end else begin
                  div_cnt_q <= div_cnt_q + DW'(1);
                  if (div_cnt_q == DIV_HALF) ssp_clk_q <= 1'b0;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign overflow   = overflow_q;
   assign fifo_level = level_q;
   assign busy       = busy_q;
   assign ssp_clk    = ssp_clk_q;
   assign ssp_frame  = ssp_frame_q;
   assign ssp_din    = ssp_din_q;

endmodule

// File: tb/tb_ssp_sample_framer.sv
// ---------------------------------------------------------------------------
// tb_ssp_sample_framer
//
// Directed bench for ssp_sample_framer (DEPTH=16, CLK_DIV=8). Stimulus pushes
// the bytes it expects to see on the serial pins into exp_q; an independent
// monitor deserialises ssp_din at each falling ssp_clk and compares whole
// bytes (and frame alignment) against that queue. Cycle-exact timing, FIFO
// levels and flag behaviour are checked directly by the stimulus process.
// Inputs change and outputs are sampled on the falling fabric edge.
// ---------------------------------------------------------------------------
module tb_ssp_sample_framer;

   localparam int DEPTH   = 16;
   localparam int CLK_DIV = 8;
   localparam int LW      = $clog2(DEPTH) + 1;

   logic          ck_1356meg = 1'b0;
   logic          reset;
   logic          enable;
   logic          flush;
   logic [7:0]    sample_data;
   logic          sample_valid;
   logic          sample_ready;
   logic          overflow_clr;
   logic          overflow;
   logic [LW-1:0] fifo_level;
   logic          busy;
   logic          ssp_clk;
   logic          ssp_frame;
   logic          ssp_din;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [7:0]    exp_q [$];

   always #5 ck_1356meg = ~ck_1356meg;

   ssp_sample_framer #(.DEPTH(DEPTH), .CLK_DIV(CLK_DIV)) dut (
      .ck_1356meg   (ck_1356meg),
      .reset        (reset),
      .enable       (enable),
      .flush        (flush),
      .sample_data  (sample_data),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .overflow_clr (overflow_clr),
      .overflow     (overflow),
      .fifo_level   (fifo_level),
      .busy         (busy),
      .ssp_clk      (ssp_clk),
      .ssp_frame    (ssp_frame),
      .ssp_din      (ssp_din)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Sample n consecutive falling edges and tally the serial outputs.
   task automatic count_window(input int n, output int clk_hi, output int rises,
                               output int frm_hi, output int din_hi, output int busy_hi);
      logic prev;
      prev    = ssp_clk;
      clk_hi  = 0;
      rises   = 0;
      frm_hi  = 0;
      din_hi  = 0;
      busy_hi = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge ck_1356meg);
         if (ssp_clk)          clk_hi++;
         if (ssp_clk && !prev) rises++;
         if (ssp_frame)        frm_hi++;
         if (ssp_din)          din_hi++;
         if (busy)             busy_hi++;
         prev = ssp_clk;
      end
   endtask

   task automatic wait_idle(input int max_cycles, input string name);
      int i;
      i = 0;
      while ((busy || ssp_clk) && i < max_cycles) begin
         @(negedge ck_1356meg);
         i++;
      end
      check({name, "_idle_timeout"}, 32'(i >= max_cycles), 0);
   endtask

   // ------------------------------------------------------------------------
   // Monitor: rebuild bytes from ssp_din at falling ssp_clk.
   // ------------------------------------------------------------------------
   initial begin : monitor
      logic       prev_clk;
      int         bit_n;
      logic [7:0] shreg;
      prev_clk = 1'b0;
      bit_n    = 0;
      shreg    = '0;
      forever begin
         @(negedge ck_1356meg);
         if (reset) begin
            prev_clk = 1'b0;
            bit_n    = 0;
         end else begin
            if (prev_clk && !ssp_clk) begin
               check("mon_frame", ssp_frame, 32'(bit_n == 0));
               shreg = {shreg[6:0], ssp_din};
               bit_n++;
               if (bit_n == 8) begin
                  bit_n = 0;
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL mon_extra_byte: got %02h, want none", shreg);
                  end else begin
                     check("mon_byte", shreg, exp_q.pop_front());
                  end
               end
            end
            prev_clk = ssp_clk;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "simulation time limit");
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin : stim
      int clk_hi, rises, frm_hi, din_hi, busy_hi, n;

      reset        = 1'b1;
      enable       = 1'b1;
      flush        = 1'b0;
      sample_data  = '0;
      sample_valid = 1'b0;
      overflow_clr = 1'b0;

      repeat (2) @(negedge ck_1356meg);
      check("rst_ready",    sample_ready, 1);
      check("rst_level",    fifo_level,   0);
      check("rst_overflow", overflow,     0);
      check("rst_busy",     busy,         0);
      check("rst_ssp_clk",  ssp_clk,      0);
      check("rst_frame",    ssp_frame,    0);
      check("rst_din",      ssp_din,      0);
      reset = 1'b0;
      repeat (2) @(negedge ck_1356meg);

      // ---- 1: single byte 0xA5, latency and occupancy -----------------------
      sample_data  = 8'hA5;
      sample_valid = 1'b1;
      exp_q.push_back(8'hA5);
      @(negedge ck_1356meg);                      // after edge N
      sample_valid = 1'b0;
      check("t1_clk_n0",   ssp_clk,    0);
      check("t1_level_n0", fifo_level, 1);
      @(negedge ck_1356meg);                      // after edge N+1 (pop)
      check("t1_clk_n1",   ssp_clk,    0);
      check("t1_busy_n1",  busy,       0);
      check("t1_level_n1", fifo_level, 0);
      count_window(64, clk_hi, rises, frm_hi, din_hi, busy_hi);  // N+2..N+65
      check("t1_clk_hi",  clk_hi,  32);
      check("t1_rises",   rises,   8);
      check("t1_frm_hi",  frm_hi,  8);
      check("t1_din_hi",  din_hi,  32);
      check("t1_busy_hi", busy_hi, 64);
      @(negedge ck_1356meg);                      // after edge N+66
      check("t1_end_clk",   ssp_clk,   0);
      check("t1_end_frame", ssp_frame, 0);
      check("t1_end_din",   ssp_din,   0);
      check("t1_end_busy",  busy,      0);
      repeat (3) @(negedge ck_1356meg);

      // ---- 2: 0x01 then 0x80 back-to-back ----------------------------------
      sample_data  = 8'h01;
      sample_valid = 1'b1;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h80);
      @(negedge ck_1356meg);                      // after N
      sample_data = 8'h80;
      @(negedge ck_1356meg);                      // after N+1: push and pop
      sample_valid = 1'b0;
      check("t2_level", fifo_level, 1);
      count_window(128, clk_hi, rises, frm_hi, din_hi, busy_hi);  // N+2..N+129
      check("t2_clk_hi",  clk_hi,  64);
      check("t2_rises",   rises,   16);
      check("t2_frm_hi",  frm_hi,  16);
      check("t2_din_hi",  din_hi,  16);
      check("t2_busy_hi", busy_hi, 128);
      @(negedge ck_1356meg);                      // after N+130
      check("t2_end_busy", busy,    0);
      check("t2_end_clk",  ssp_clk, 0);
      repeat (3) @(negedge ck_1356meg);

      // ---- 3: fill while disabled, overflow set/clear priority -------------
      enable       = 1'b0;
      sample_valid = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         sample_data = 8'(i * 7 + 3);
         @(negedge ck_1356meg);
      end
      check("t3_level_full", fifo_level,   16);
      check("t3_ready_full", sample_ready, 0);
      check("t3_ovf_before", overflow,     0);
      check("t3_busy_dis",   busy,         0);
      sample_data = 8'hEE;                         // 17th push, dropped
      @(negedge ck_1356meg);
      check("t3_ovf_set",    overflow,   1);
      check("t3_level_drop", fifo_level, 16);
      overflow_clr = 1'b1;                         // clear with simultaneous drop
      @(negedge ck_1356meg);
      check("t3_ovf_set_wins", overflow, 1);
      sample_valid = 1'b0;                         // clean clear
      @(negedge ck_1356meg);
      check("t3_ovf_cleared", overflow, 0);
      overflow_clr = 1'b0;
      flush        = 1'b1;
      @(negedge ck_1356meg);
      flush = 1'b0;
      check("t3_flush_level", fifo_level,   0);
      check("t3_flush_ready", sample_ready, 1);
      enable = 1'b1;
      repeat (3) @(negedge ck_1356meg);
      check("t3_no_start", busy, 0);

      // ---- 4: flush with a byte in flight ----------------------------------
      sample_data  = 8'h11;
      sample_valid = 1'b1;
      exp_q.push_back(8'h11);
      @(negedge ck_1356meg);                      // after N
      for (int i = 0; i < 5; i++) begin
         sample_data = 8'h21 + 8'(i);
         @(negedge ck_1356meg);
      end
      sample_valid = 1'b0;
      check("t4_level_pre", fifo_level, 5);
      check("t4_busy_pre",  busy,       1);
      flush = 1'b1;
      @(negedge ck_1356meg);
      flush = 1'b0;
      check("t4_level_flush", fifo_level, 0);
      check("t4_busy_flush",  busy,       1);
      wait_idle(80, "t4");
      count_window(80, clk_hi, rises, frm_hi, din_hi, busy_hi);
      check("t4_no_frame", frm_hi,  0);
      check("t4_no_busy",  busy_hi, 0);

      // ---- 5: asynchronous reset during bit 4 of 0xFF ----------------------
      sample_data  = 8'hFF;
      sample_valid = 1'b1;
      exp_q.push_back(8'hFF);
      @(negedge ck_1356meg);                      // after N
      sample_valid = 1'b0;
      repeat (27) @(negedge ck_1356meg);          // after N+27: bit 4, clk high
      check("t5_pre_busy", busy,    1);
      check("t5_pre_din",  ssp_din, 1);
      check("t5_pre_clk",  ssp_clk, 1);
      #2;
      reset = 1'b1;
      exp_q.delete();                              // abandoned byte
      #1;                                          // no clock edge in between
      check("t5_rst_clk",   ssp_clk,    0);
      check("t5_rst_frame", ssp_frame,  0);
      check("t5_rst_din",   ssp_din,    0);
      check("t5_rst_busy",  busy,       0);
      check("t5_rst_level", fifo_level, 0);
      repeat (2) @(negedge ck_1356meg);
      reset = 1'b0;
      @(negedge ck_1356meg);
      sample_data  = 8'h3C;
      sample_valid = 1'b1;
      exp_q.push_back(8'h3C);
      @(negedge ck_1356meg);                      // after N
      sample_valid = 1'b0;
      repeat (2) @(negedge ck_1356meg);           // after N+2
      check("t5_post_busy",  busy,      1);
      check("t5_post_frame", ssp_frame, 1);
      check("t5_post_din",   ssp_din,   0);
      wait_idle(80, "t5");

      // ---- 6: disable mid-byte with 3 queued, then re-enable ---------------
      repeat (3) @(negedge ck_1356meg);
      sample_valid = 1'b1;
      sample_data  = 8'hC3; exp_q.push_back(8'hC3);
      @(negedge ck_1356meg);                      // after N
      sample_data  = 8'h5A; exp_q.push_back(8'h5A);
      @(negedge ck_1356meg);
      sample_data  = 8'h0F; exp_q.push_back(8'h0F);
      @(negedge ck_1356meg);
      sample_data  = 8'hF0; exp_q.push_back(8'hF0);
      @(negedge ck_1356meg);                      // after N+3
      sample_valid = 1'b0;
      check("t6_level_q", fifo_level, 3);
      repeat (9) @(negedge ck_1356meg);           // after N+12: bit 6
      enable = 1'b0;
      check("t6_busy_bit6", busy, 1);
      wait_idle(80, "t6a");
      check("t6_level_idle", fifo_level, 3);
      repeat (20) @(negedge ck_1356meg);
      check("t6_stay_idle", busy,       0);
      check("t6_stay_lvl",  fifo_level, 3);
      enable = 1'b1;
      n = 0;
      while (!busy && n < 10) begin
         @(negedge ck_1356meg);
         n++;
      end
      check("t6_restart_timeout", 32'(n >= 10), 0);
      n = 0;
      while (busy && n < 400) begin
         @(negedge ck_1356meg);
         n++;
      end
      check("t6_stream_len", n,          192);
      check("t6_level_end",  fifo_level, 0);

      repeat (10) @(negedge ck_1356meg);
      check("end_exp_q_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ssp_sample_framer.md
Name: ssp_sample_framer

Overview:
- Buffers 8-bit samples from an active mode module and serialises them MSB-first onto the SSP pins toward the ARM.
- Generates ssp_clk, ssp_frame and ssp_din from a single fabric clock.
- Sits between a mode module's sample output and the top-level ssp_* output mux, replacing per-mode ad-hoc shifters.
- Adds FIFO decoupling, valid/ready flow control and overflow reporting.

Parameters:
DEPTH, 16, FIFO depth in samples; power of two, >= 2.
CLK_DIV, 8, fabric clocks per SSP bit period; even, >= 2 (8 gives 1.695 MHz ssp_clk from 13.56 MHz).

Ports:
ck_1356meg  input  1  fabric clock; all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = may start new bytes; 0 = finish current byte, then idle.
flush  input  1  synchronous; empties FIFO in one cycle.
sample_data  input  8  sample to send.
sample_valid  input  1  sample_data valid this cycle.
sample_ready  output  1  FIFO can accept (= not full).
overflow_clr  input  1  clears overflow.
overflow  output  1  sticky: sample offered while not ready.
fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
busy  output  1  byte currently being shifted.
ssp_clk  output  1  serial clock to ARM.
ssp_frame  output  1  high during bit 7 period of each byte.
ssp_din  output  1  serial data, MSB first.

Behaviour:
- Reset (async, immediate): FIFO empty, fifo_level=0, sample_ready=1, overflow=0, busy=0, ssp_clk=0, ssp_frame=0, ssp_din=0, state IDLE. A byte in flight is abandoned, not resumed.
- Push: sample_valid & sample_ready at an edge writes sample_data; fifo_level increments that edge.
- sample_ready = (fifo_level != DEPTH). It is not raised by a same-cycle pop.
- Drops: sample_valid & !sample_ready drops the sample and sets overflow at that edge. overflow_clr clears overflow. If set and clear occur in the same cycle, set wins.
- flush: empties FIFO and sets fifo_level=0 at that edge. It overrides a same-cycle push. The byte in flight completes.
- Bit period = CLK_DIV clocks: ssp_clk=1 for the first CLK_DIV/2 clocks, 0 for the remainder. ssp_din and ssp_frame change only on the edge where ssp_clk rises, so they are stable at ssp_clk falling, where the ARM samples.
- State IDLE:
  - ssp_clk=0, ssp_frame=0, ssp_din=0, busy=0.
  - If enable & fifo_level!=0: pop at edge E, load shift register, go to SHIFT.
  - At E+1: ssp_clk=1, ssp_frame=1, ssp_din=bit7, busy=1.
  - Latency: push into empty FIFO at edge N while IDLE & enabled gives the first ssp_clk rise at N+2. There is no FIFO bypass.
- State SHIFT:
  - Bit counter runs 7 down to 0.
  - ssp_frame=1 only during the bit-7 period.
  - On each new bit period, ssp_din = next lower bit.
- End of bit 0 period (the edge that would begin the next period):
  - If enable & FIFO not empty: pop at that edge, and the next byte's bit 7 begins on that same edge. No gap: ssp_clk continues periodically and ssp_frame rises again.
  - Otherwise return to IDLE; all ssp outputs 0 on that edge.
- Byte occupancy: one pop per byte. A byte occupies exactly 8*CLK_DIV clocks.
- enable deasserted mid-byte: current byte completes all 8 bits, then IDLE. Pushes are still accepted while disabled.
- Push and pop in the same cycle: fifo_level unchanged. Pointers wrap modulo DEPTH.

Test Plan:
- Idle, enabled, CLK_DIV=8; push 0xA5 at edge N -> ssp_clk first rise at N+2. ssp_din over 8 periods = 1,0,1,0,0,1,0,1. ssp_frame high for the first 8 clocks only. Outputs back to 0 at N+66; busy high N+2..N+65.
- Push 0x01 then 0x80 on consecutive cycles -> 16 uninterrupted ssp_clk periods. ssp_frame high in periods 1 and 9. ssp_din high only in periods 8 and 9.
- enable=0; push 16 samples -> fifo_level=16, sample_ready=0. 17th push dropped, overflow=1 next edge. overflow_clr with a simultaneous drop keeps overflow=1. A clean overflow_clr clears it.
- Fill 5 samples with enable=1 and a byte in flight; assert flush -> fifo_level=0 next edge. The in-flight byte finishes all 8 bits, then IDLE with no further frame.
- Assert reset during bit 4 of 0xFF -> ssp_clk/ssp_frame/ssp_din/busy go 0 without a clock edge, fifo_level=0. After release, push 0x3C -> clean byte with frame, no stale bits.
- Drop enable during bit 6 with 3 samples queued -> the current byte completes, then IDLE, fifo_level=3. Re-enable -> 3 bytes stream back-to-back.
